// File: rtl/id_fwd_stage.sv
// Registered MIPS decode stage: decodes the IF/ID instruction, resolves
// operands with EX/MEM forwarding, interlocks on load-use hazards, resolves
// branches/jumps in ID and presents the result in a valid/ready register.
module id_fwd_stage #(
  parameter int DATA_W      = 32,
  parameter bit DELAY_SLOT  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [31:0]            i_pc,
  input  logic [31:0]            i_inst,
  output logic [4:0]             o_readAddrLeft,
  output logic [4:0]             o_readAddrRight,
  output logic                   o_readEnableLeft,
  output logic                   o_readEnableRight,
  input  logic [DATA_W-1:0]      i_readValueLeft,
  input  logic [DATA_W-1:0]      i_readValueRight,
  input  logic                   i_exWrite,
  input  logic                   i_exIsLoad,
  input  logic [4:0]             i_exDest,
  input  logic [DATA_W-1:0]      i_exValue,
  input  logic                   i_memWrite,
  input  logic [4:0]             i_memDest,
  input  logic [DATA_W-1:0]      i_memValue,
  input  logic                   i_flush,
  output logic                   o_takeBranch,
  output logic [31:0]            o_jpc,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [4:0]             o_exop,
  output logic [4:0]             o_dest,
  output logic [DATA_W-1:0]      o_srcLeft,
  output logic [DATA_W-1:0]      o_srcRight,
  output logic [STALL_CNT_W-1:0] o_stallCount
);

  typedef enum logic [4:0] {
    EX_NOP  = 5'd0,  EX_AND  = 5'd1,  EX_OR    = 5'd2,  EX_XOR  = 5'd3,
    EX_NOR  = 5'd4,  EX_SLL  = 5'd5,  EX_SRL   = 5'd6,  EX_SRA  = 5'd7,
    EX_MFHI = 5'd8,  EX_MFLO = 5'd9,  EX_MTHI  = 5'd10, EX_MTLO = 5'd11,
    EX_ADD  = 5'd12, EX_ADDU = 5'd13, EX_SUB   = 5'd14, EX_SUBU = 5'd15,
    EX_MULT = 5'd16, EX_MULTU = 5'd17, EX_SLT  = 5'd18, EX_SLTU = 5'd19
  } ex_op_e;

  typedef enum logic [1:0] {L_RS, L_RT, L_ZERO} lsel_e;
  typedef enum logic [2:0] {R_RT, R_RS, R_SA, R_SEIMM, R_ZEIMM, R_LUI, R_NPC, R_ZERO} rsel_e;
  typedef enum logic [3:0] {BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ, BR_J, BR_JR} br_e;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] npc;

  assign op     = i_inst[31:26];
  assign rs     = i_inst[25:21];
  assign rt     = i_inst[20:16];
  assign rd     = i_inst[15:11];
  assign sa     = i_inst[10:6];
  assign funct  = i_inst[5:0];
  assign imm    = i_inst[15:0];
  assign target = i_inst[25:0];
  assign npc    = i_pc + 32'd4;

  ex_op_e     dec_op;
  logic [4:0] dec_dest;
  logic       use_left, use_right;
  lsel_e      lsel;
  rsel_e      rsel;
  br_e        br;

  // Instruction decode: EX op, destination, used sources and operand selects
  always_comb begin
    dec_op    = EX_NOP;
    dec_dest  = '0;
    use_left  = 1'b0;
    use_right = 1'b0;
    lsel      = L_ZERO;
    rsel      = R_ZERO;
    br        = BR_NONE;
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03: begin
            if (sa != 5'd0) begin
              case (funct)
                6'h00:   dec_op = EX_SLL;
                6'h02:   dec_op = EX_SRL;
                default: dec_op = EX_SRA;
              endcase
              use_right = 1'b1;
              lsel      = L_RT;
              rsel      = R_SA;
              dec_dest  = rd;
            end
          end
          6'h04, 6'h06, 6'h07: begin
            case (funct)
              6'h04:   dec_op = EX_SLL;
              6'h06:   dec_op = EX_SRL;
              default: dec_op = EX_SRA;
            endcase
            use_left  = 1'b1;
            use_right = 1'b1;
            lsel      = L_RT;
            rsel      = R_RS;
            dec_dest  = rd;
          end
          6'h08: begin
            use_left = 1'b1;
            br       = BR_JR;
          end
          6'h09: begin
            use_left = 1'b1;
            br       = BR_JR;
            dec_op   = EX_OR;
            rsel     = R_NPC;
            dec_dest = 5'd31;
          end
          6'h10: begin dec_op = EX_MFHI; dec_dest = rd; end
          6'h12: begin dec_op = EX_MFLO; dec_dest = rd; end
          6'h11: begin dec_op = EX_MTHI; use_left = 1'b1; lsel = L_RS; end
          6'h13: begin dec_op = EX_MTLO; use_left = 1'b1; lsel = L_RS; end
          6'h18, 6'h19, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            case (funct)
              6'h18:   dec_op = EX_MULT;
              6'h19:   dec_op = EX_MULTU;
              6'h20:   dec_op = EX_ADD;
              6'h21:   dec_op = EX_ADDU;
              6'h22:   dec_op = EX_SUB;
              6'h23:   dec_op = EX_SUBU;
              6'h24:   dec_op = EX_AND;
              6'h25:   dec_op = EX_OR;
              6'h26:   dec_op = EX_XOR;
              6'h27:   dec_op = EX_NOR;
              6'h2A:   dec_op = EX_SLT;
              default: dec_op = EX_SLTU;
            endcase
            use_left  = 1'b1;
            use_right = 1'b1;
            lsel      = L_RS;
            rsel      = R_RT;
            dec_dest  = (funct == 6'h18 || funct == 6'h19) ? 5'd0 : rd;
          end
          default: ;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) begin use_left = 1'b1; br = BR_LTZ; end
        else if (rt == 5'd1) begin use_left = 1'b1; br = BR_GEZ; end
      end
      6'h02: br = BR_J;
      6'h03: begin
        br       = BR_J;
        dec_op   = EX_OR;
        rsel     = R_NPC;
        dec_dest = 5'd31;
      end
      6'h04: begin use_left = 1'b1; use_right = 1'b1; br = BR_EQ; end
      6'h05: begin use_left = 1'b1; use_right = 1'b1; br = BR_NE; end
      6'h06: begin use_left = 1'b1; br = BR_LEZ; end
      6'h07: begin use_left = 1'b1; br = BR_GTZ; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        case (op)
          6'h08:   begin dec_op = EX_ADD;  rsel = R_SEIMM; end
          6'h09:   begin dec_op = EX_ADDU; rsel = R_SEIMM; end
          6'h0A:   begin dec_op = EX_SLT;  rsel = R_SEIMM; end
          6'h0B:   begin dec_op = EX_SLTU; rsel = R_SEIMM; end
          6'h0C:   begin dec_op = EX_AND;  rsel = R_ZEIMM; end
          6'h0D:   begin dec_op = EX_OR;   rsel = R_ZEIMM; end
          default: begin dec_op = EX_XOR;  rsel = R_ZEIMM; end
        endcase
        use_left = 1'b1;
        lsel     = L_RS;
        dec_dest = rt;
      end
      6'h0F: begin
        dec_op   = EX_OR;
        rsel     = R_LUI;
        dec_dest = rt;
      end
      default: ;
    endcase
  end

  // EX beats MEM beats register file; EX results of loads are not ready yet
  function automatic logic [DATA_W-1:0] fwd(input logic [4:0] addr,
                                            input logic [DATA_W-1:0] rf_value);
    if (addr == 5'd0) return '0;
    if (i_exWrite && !i_exIsLoad && i_exDest == addr) return i_exValue;
    if (i_memWrite && i_memDest == addr) return i_memValue;
    return rf_value;
  endfunction

  logic [DATA_W-1:0] fwd_left, fwd_right, src_left, src_right;
  logic              hazard, can_advance, accept, taken, redirect;
  logic              squash;
  logic [31:0]       br_target;

  assign fwd_left  = fwd(rs, i_readValueLeft);
  assign fwd_right = fwd(rt, i_readValueRight);

  assign o_readAddrLeft    = rs;
  assign o_readAddrRight   = rt;
  assign o_readEnableLeft  = use_left & i_valid;
  assign o_readEnableRight = use_right & i_valid;

  assign hazard = i_valid & i_exWrite & i_exIsLoad & (i_exDest != 5'd0) &
                  ((use_left & (i_exDest == rs)) | (use_right & (i_exDest == rt)));

  assign can_advance = !o_valid | i_ready;
  assign o_ready     = i_flush | (can_advance & !hazard);
  assign accept      = i_valid & o_ready & !i_flush;
  assign br_target   = npc + {{14{imm[15]}}, imm, 2'b00};

  // Branch condition on forwarded operands and redirect target
  always_comb begin
    taken = 1'b0;
    o_jpc = br_target;
    case (br)
      BR_EQ:  taken = (fwd_left == fwd_right);
      BR_NE:  taken = (fwd_left != fwd_right);
      BR_LEZ: taken = fwd_left[DATA_W-1] | (fwd_left == '0);
      BR_GTZ: taken = !fwd_left[DATA_W-1] & (fwd_left != '0);
      BR_LTZ: taken = fwd_left[DATA_W-1];
      BR_GEZ: taken = !fwd_left[DATA_W-1];
      BR_J:   begin taken = 1'b1; o_jpc = {npc[31:28], target, 2'b00}; end
      BR_JR:  begin taken = 1'b1; o_jpc = 32'(fwd_left); end
      default: ;
    endcase
  end

  assign redirect     = accept & !squash & taken;
  assign o_takeBranch = redirect & !i_rst;

  // Operand selection after forwarding
  always_comb begin
    src_left = '0;
    case (lsel)
      L_RS:    src_left = fwd_left;
      L_RT:    src_left = fwd_right;
      default: src_left = '0;
    endcase
    src_right = '0;
    case (rsel)
      R_RT:    src_right = fwd_right;
      R_RS:    src_right = fwd_left;
      R_SA:    src_right = DATA_W'(sa);
      R_SEIMM: src_right = {{(DATA_W-16){imm[15]}}, imm};
      R_ZEIMM: src_right = DATA_W'(imm);
      R_LUI:   src_right = DATA_W'({imm, 16'h0000});
      R_NPC:   src_right = DATA_W'(npc);
      default: src_right = '0;
    endcase
  end

  // Output register, squash flag and saturating stall counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_exop       <= EX_NOP;
      o_dest       <= '0;
      o_srcLeft    <= '0;
      o_srcRight   <= '0;
      squash       <= 1'b0;
      o_stallCount <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      squash  <= 1'b0;
    end else if (accept) begin
      if (squash) begin
        o_valid <= 1'b0;
        squash  <= 1'b0;
      end else begin
        o_valid    <= 1'b1;
        o_exop     <= dec_op;
        o_dest     <= dec_dest;
        o_srcLeft  <= src_left;
        o_srcRight <= src_right;
        squash     <= !DELAY_SLOT && taken;
      end
    end else if (can_advance) begin
      o_valid <= 1'b0;
      if (hazard && o_stallCount != '1)
        o_stallCount <= o_stallCount + STALL_CNT_W'(1);
    end
  end

endmodule
